// File: rtl/modsq_carry_normalize_if.sv
// Bus between the modular squaring wrapper output and the carry normalizer.
// The master side drives the redundant coefficient bus and its valid pulse.
// The slave side returns the canonical result and the status flags.
interface modsq_carry_normalize_if #(
    parameter int SQ_IN_BITS  = 2112,
    parameter int RESULT_BITS = 1056
);
    logic                   in_valid;
    logic [SQ_IN_BITS-1:0]  sq_in;
    logic                   busy;
    logic                   out_valid;
    logic [RESULT_BITS-1:0] result;
    logic [1:0]             carry_out;
    logic                   overrun;

    modport master (
        output in_valid,
        output sq_in,
        input  busy,
        input  out_valid,
        input  result,
        input  carry_out,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  sq_in,
        output busy,
        output out_valid,
        output result,
        output carry_out,
        output overrun
    );
endinterface

// File: rtl/modsq_carry_normalize.sv
// Serial carry normalizer for the modular squaring result.
// On a valid pulse it captures the redundant coefficients, where each one is
// BIT_LEN bits wide and the coefficients are spaced WORD_LEN bits apart. It
// then ripples the carries through ELEMS_PER_CYCLE coefficients per clock and
// presents the exact binary sum with a one-cycle completion pulse.
module modsq_carry_normalize #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int BIT_LEN            = 17,
    parameter int ELEMS_PER_CYCLE    = 1,
    parameter int SQ_IN_BITS         = NUM_ELEMENTS * WORD_LEN * 2
) (
    input  logic                      clk,
    input  logic                      reset,
    modsq_carry_normalize_if.slave    bus
);

    localparam int RES_W      = NUM_ELEMENTS * WORD_LEN;
    localparam int HOLD_W     = NUM_ELEMENTS * BIT_LEN;
    localparam int FIELD_W    = 2 * WORD_LEN;
    localparam int SUM_W      = BIT_LEN + 1;
    localparam int CARRY_W    = 2;
    localparam int GRP_W      = ELEMS_PER_CYCLE * WORD_LEN;
    localparam int GRP_HOLD_W = ELEMS_PER_CYCLE * BIT_LEN;
    localparam int IDX_W      = $clog2(NUM_ELEMENTS + 1);

    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(ELEMS_PER_CYCLE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEMENTS - ELEMS_PER_CYCLE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A partial last group would leave coefficients unprocessed.
    if ((NUM_ELEMENTS % ELEMS_PER_CYCLE) != 0) begin : g_bad_elems_per_cycle
        $error("ELEMS_PER_CYCLE must divide NUM_ELEMENTS");
    end

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CARRY_W-1:0] carry_r;
    logic [HOLD_W-1:0]  hold_r;
    logic [RES_W-1:0]   result_r;
    logic [CARRY_W-1:0] carry_out_r;
    logic               busy_r;
    logic               out_valid_r;
    logic               overrun_r;

    logic [HOLD_W-1:0]  hold_cap_s;
    logic [HOLD_W-1:0]  hold_next_s;
    logic [RES_W-1:0]   result_next_s;
    logic [GRP_W-1:0]   group_s;
    logic [CARRY_W-1:0] carry_chain_s;
    logic [SUM_W-1:0]   sum_s;
    logic               unused_sq_bits_s;

    // Keep only the significant low bits of each 2*WORD_LEN-wide input field.
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_capture
        assign hold_cap_s[j*BIT_LEN +: BIT_LEN] = bus.sq_in[j*FIELD_W +: BIT_LEN];
    end

    // The upper field bits are don't-care padding from the wrapper.
    assign unused_sq_bits_s = ^bus.sq_in;

    // Ripple the carry through the lowest unprocessed coefficients, in ascending order.
    always_comb begin
        carry_chain_s = carry_r;
        group_s       = '0;
        sum_s         = '0;
        for (int e = 0; e < ELEMS_PER_CYCLE; e++) begin
            sum_s = SUM_W'(hold_r[e*BIT_LEN +: BIT_LEN]) + SUM_W'(carry_chain_s);
            group_s[e*WORD_LEN +: WORD_LEN] = sum_s[WORD_LEN-1:0];
            carry_chain_s = sum_s[WORD_LEN +: CARRY_W];
        end
    end

    // Consume the holding register from the bottom and shift the finished words in from the top.
    always_comb begin
        hold_next_s   = hold_r >> GRP_HOLD_W;
        result_next_s = result_r >> GRP_W;
        result_next_s[RES_W-1 -: GRP_W] = group_s;
    end

    // Control FSM, datapath registers and the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            carry_r     <= 2'd0;
            hold_r      <= '0;
            result_r    <= '0;
            carry_out_r <= 2'd0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                    if (bus.in_valid) begin
                        hold_r      <= hold_cap_s;
                        idx_r       <= '0;
                        carry_r     <= 2'd0;
                        result_r    <= '0;
                        carry_out_r <= 2'd0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    hold_r   <= hold_next_s;
                    result_r <= result_next_s;
                    carry_r  <= carry_chain_s;
                    idx_r    <= idx_r + IDX_STEP;
                    if (idx_r == IDX_LAST) begin
                        carry_out_r <= carry_chain_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for a valid pulse that arrived while an operation was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (bus.in_valid && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overrun   = overrun_r;

endmodule
